// File: rtl/fc_layer_sequencer.sv
// Operand-feed and result-collection sequencer for one fully connected layer
// on a 16-lane signed dot-product ALU: activations once, then weights+bias per neuron.
module fc_layer_sequencer #(
    parameter int NUM_OUT = 8,
    parameter int ADDR_W  = 10,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                act_rd,
    output logic [ADDR_W-1:0]   act_addr,
    input  logic [15:0]         act_data,
    output logic                w_rd,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [15:0]         w_data,
    output logic [255:0]        alu_a,
    output logic [255:0]        alu_w,
    output logic [15:0]         alu_bias,
    input  logic [15:0]         alu_result,
    output logic                res_we,
    output logic [ADDR_W-1:0]   res_addr,
    output logic [15:0]         res_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_ACT = 3'd1,
        S_LOAD_W   = 3'd2,
        S_EXEC     = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(NUM_OUT - 1);

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                act_rd_q, act_rd_d;
    logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
    logic                w_rd_q, w_rd_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [255:0]        alu_a_q, alu_a_d;
    logic [255:0]        alu_w_q, alu_w_d;
    logic [15:0]         alu_bias_q, alu_bias_d;
    logic                res_we_q, res_we_d;
    logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
    logic [15:0]         res_data_q, res_data_d;
    logic [3:0]          lane_idx_s;

    function automatic logic [15:0] relu_f(input logic [15:0] v);
        if (RELU_EN && v[15]) begin
            return 16'h0000;
        end else begin
            return v;
        end
    endfunction

    // Data read at count c arrives at count c+1, so the lane written lags the count by one
    assign lane_idx_s = cnt_q[3:0] - 4'd1;

    // Next-state, operand capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        alu_a_d    = alu_a_q;
        alu_w_d    = alu_w_q;
        alu_bias_d = alu_bias_q;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_ACT;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_ACT: begin
                if (cnt_q != 5'd0) begin
                    alu_a_d[16*lane_idx_s +: 16] = act_data;
                end else begin
                    alu_a_d = alu_a_q;
                end
                if (cnt_q == 5'd16) begin
                    state_d = S_LOAD_W;
                    cnt_d   = 5'd0;
                    n_d     = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == 5'd17) begin
                    alu_bias_d = w_data;
                    state_d    = S_EXEC;
                    cnt_d      = 5'd0;
                end else begin
                    if (cnt_q != 5'd0) begin
                        alu_w_d[16*lane_idx_s +: 16] = w_data;
                    end else begin
                        alu_w_d = alu_w_q;
                    end
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_EXEC: begin
                res_data_d = relu_f(alu_result);
                res_addr_d = n_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                if (n_q == LAST_N) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d   = 5'd0;
                    state_d = S_LOAD_W;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and addresses are registered, so they are derived from the state being entered
        busy_d   = (state_d == S_LOAD_ACT) || (state_d == S_LOAD_W) ||
                   (state_d == S_EXEC) || (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        res_we_d = (state_d == S_WRITE);
        act_rd_d = (state_d == S_LOAD_ACT) && (cnt_d < 5'd16);
        w_rd_d   = (state_d == S_LOAD_W) && (cnt_d < 5'd17);

        if (act_rd_d) begin
            act_addr_d = ADDR_W'(cnt_d);
        end else begin
            act_addr_d = act_addr_q;
        end

        // n*17+k, wrapping naturally at ADDR_W bits
        if (w_rd_d) begin
            w_addr_d = (n_d << 4) + n_d + ADDR_W'(cnt_d);
        end else begin
            w_addr_d = w_addr_q;
        end
    end

    // State, counters, operand buses and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            n_q        <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            act_rd_q   <= 1'b0;
            act_addr_q <= {ADDR_W{1'b0}};
            w_rd_q     <= 1'b0;
            w_addr_q   <= {ADDR_W{1'b0}};
            alu_a_q    <= 256'd0;
            alu_w_q    <= 256'd0;
            alu_bias_q <= 16'h0000;
            res_we_q   <= 1'b0;
            res_addr_q <= {ADDR_W{1'b0}};
            res_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            act_rd_q   <= act_rd_d;
            act_addr_q <= act_addr_d;
            w_rd_q     <= w_rd_d;
            w_addr_q   <= w_addr_d;
            alu_a_q    <= alu_a_d;
            alu_w_q    <= alu_w_d;
            alu_bias_q <= alu_bias_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign act_rd   = act_rd_q;
    assign act_addr = act_addr_q;
    assign w_rd     = w_rd_q;
    assign w_addr   = w_addr_q;
    assign alu_a    = alu_a_q;
    assign alu_w    = alu_w_q;
    assign alu_bias = alu_bias_q;
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: main instance NUM_OUT=3/ReLU on, second instance NUM_OUT=1/ReLU off,
// sharing bench memories and a behavioural Q8.8 dot-product ALU.
module tb_fc_layer_sequencer;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic          rst_n_m, start_m, busy_m, done_m, act_rd_m, w_rd_m, res_we_m;
    logic [AW-1:0] act_addr_m, w_addr_m, res_addr_m;
    logic [15:0]   act_data_m, w_data_m, alu_bias_m, alu_result_m, res_data_m;
    logic [255:0]  alu_a_m, alu_w_m;
    // second instance signals
    logic          rst_n_s, start_s, busy_s, done_s, act_rd_s, w_rd_s, res_we_s;
    logic [AW-1:0] act_addr_s, w_addr_s, res_addr_s;
    logic [15:0]   act_data_s, w_data_s, alu_bias_s, alu_result_s, res_data_s;
    logic [255:0]  alu_a_s, alu_w_s;

    fc_layer_sequencer #(.NUM_OUT(3), .ADDR_W(AW), .RELU_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n_m), .start(start_m), .busy(busy_m), .done(done_m),
        .act_rd(act_rd_m), .act_addr(act_addr_m), .act_data(act_data_m),
        .w_rd(w_rd_m), .w_addr(w_addr_m), .w_data(w_data_m),
        .alu_a(alu_a_m), .alu_w(alu_w_m), .alu_bias(alu_bias_m), .alu_result(alu_result_m),
        .res_we(res_we_m), .res_addr(res_addr_m), .res_data(res_data_m)
    );

    fc_layer_sequencer #(.NUM_OUT(1), .ADDR_W(AW), .RELU_EN(1'b0)) u_dut_nr (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .done(done_s),
        .act_rd(act_rd_s), .act_addr(act_addr_s), .act_data(act_data_s),
        .w_rd(w_rd_s), .w_addr(w_addr_s), .w_data(w_data_s),
        .alu_a(alu_a_s), .alu_w(alu_w_s), .alu_bias(alu_bias_s), .alu_result(alu_result_s),
        .res_we(res_we_s), .res_addr(res_addr_s), .res_data(res_data_s)
    );

    logic [15:0] act_mem [0:15];
    logic [15:0] w_mem   [0:63];

    // 1-cycle latency memories; non-read cycles return a marker value
    always @(posedge clk) begin
        act_data_m <= act_rd_m ? act_mem[act_addr_m[3:0]] : 16'hBAD0;
        w_data_m   <= w_rd_m   ? w_mem[w_addr_m[5:0]]     : 16'hBAD0;
        act_data_s <= act_rd_s ? act_mem[act_addr_s[3:0]] : 16'hBAD0;
        w_data_s   <= w_rd_s   ? w_mem[w_addr_s[5:0]]     : 16'hBAD0;
    end

    function automatic logic [15:0] alu_f(input logic [255:0] a, input logic [255:0] w,
                                          input logic [15:0] b);
        logic signed [31:0] acc;
        acc = 32'sd0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + $signed(a[16*i +: 16]) * $signed(w[16*i +: 16]);
        end
        return acc[23:8] + b;
    endfunction

    assign alu_result_m = alu_f(alu_a_m, alu_w_m, alu_bias_m);
    assign alu_result_s = alu_f(alu_a_s, alu_w_s, alu_bias_s);

    int n_vec = 0;
    int n_err = 0;
    logic [25:0]   exp_m [$];
    logic [25:0]   exp_s [$];
    logic [AW-1:0] waddr_q [$];
    bit chk_waddr = 1'b0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever a DUT writes or issues a weight read
    always @(negedge clk) begin
        if (res_we_m) begin
            if (exp_m.size() == 0) chk("unexpected_write_m", {res_addr_m, res_data_m}, 256'h1_0000_0000);
            else chk("write_m", {res_addr_m, res_data_m}, exp_m.pop_front());
        end
        if (res_we_s) begin
            if (exp_s.size() == 0) chk("unexpected_write_s", {res_addr_s, res_data_s}, 256'h1_0000_0000);
            else chk("write_s", {res_addr_s, res_data_s}, exp_s.pop_front());
        end
        if (w_rd_m && chk_waddr) begin
            if (waddr_q.size() == 0) chk("unexpected_wrd", w_addr_m, 256'h1_0000_0000);
            else chk("w_addr", w_addr_m, waddr_q.pop_front());
        end
    end

    task automatic push_waddr(input int n_out);
        for (int a = 0; a < 17 * n_out; a++) waddr_q.push_back(AW'(a));
    endtask

    task automatic run(input bit sel, input int n_out, input int restart_at, input int reset_at);
        int cyc, busy_cnt, done_cnt, done_cyc;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        @(negedge clk);
        if (sel) start_s = 1'b1; else start_m = 1'b1;
        @(negedge clk);
        start_s = 1'b0; start_m = 1'b0;
        cyc = 1;
        while (cyc <= 21 + 20 * n_out) begin
            if (sel ? busy_s : busy_m) busy_cnt++;
            if (sel ? done_s : done_m) begin done_cnt++; done_cyc = cyc; end
            start_m = (!sel && cyc == restart_at);
            if (cyc == reset_at) begin
                #2 rst_n_m = 1'b0;
                #1;
                chk("rst_ctl", {busy_m, done_m, act_rd_m, w_rd_m, res_we_m}, 256'd0);
                chk("rst_addr", {act_addr_m, w_addr_m, res_addr_m}, 256'd0);
                chk("rst_alu_a", alu_a_m, 256'd0);
                chk("rst_alu_w", alu_w_m, 256'd0);
                chk("rst_bias_res", {alu_bias_m, res_data_m}, 256'd0);
                repeat (3) @(negedge clk);
                rst_n_m = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start_m = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_cyc, 18 + 20 * n_out);
        chk("busy_cycles", busy_cnt, 17 + 20 * n_out);
    endtask

    initial begin
        logic [255:0] exp_a;
        rst_n_m = 1'b0; rst_n_s = 1'b0; start_m = 1'b0; start_s = 1'b0;
        #12;
        chk("reset_ctl", {busy_m, done_m, act_rd_m, w_rd_m, res_we_m, busy_s, done_s}, 256'd0);
        chk("reset_buses", {alu_a_m[127:0], alu_w_m[127:0]}, 256'd0);
        chk("reset_res", {res_addr_m, res_data_m, alu_bias_m, w_addr_m, act_addr_m}, 256'd0);
        @(negedge clk); rst_n_m = 1'b1; rst_n_s = 1'b1;

        // Run A: 0x1005, ReLU-clipped F000, bias-only 3; restart pulse at cycle 10
        for (int k = 0; k < 16; k++) act_mem[k] = 16'h0100;
        for (int k = 0; k < 64; k++) w_mem[k] = 16'h0000;
        for (int k = 0; k < 16; k++) begin w_mem[k] = 16'h0100; w_mem[17 + k] = 16'hFF00; end
        w_mem[16] = 16'h0005; w_mem[33] = 16'h0000; w_mem[50] = 16'h0003;
        exp_m.push_back({10'd0, 16'h1005});
        exp_m.push_back({10'd1, 16'h0000});
        exp_m.push_back({10'd2, 16'h0003});
        push_waddr(3); chk_waddr = 1'b1;
        run(1'b0, 3, 10, -1);
        chk("runA_drained", exp_m.size() + waddr_q.size(), 0);

        // Second instance, ReLU off: 0x1005 then F000 passes through
        exp_s.push_back({10'd0, 16'h1005});
        run(1'b1, 1, -1, -1);
        for (int k = 0; k < 16; k++) w_mem[k] = 16'hFF00;
        w_mem[16] = 16'h0000;
        exp_s.push_back({10'd0, 16'hF000});
        run(1'b1, 1, -1, -1);
        chk("runS_drained", exp_s.size(), 0);

        // Run B: lane ordering and bias-only neurons
        for (int k = 0; k < 16; k++) act_mem[k] = 16'(k + 1);
        for (int k = 0; k < 64; k++) w_mem[k] = 16'h0000;
        w_mem[16] = 16'h0001; w_mem[33] = 16'h0002; w_mem[50] = 16'h0003;
        exp_m.push_back({10'd0, 16'h0001});
        exp_m.push_back({10'd1, 16'h0002});
        exp_m.push_back({10'd2, 16'h0003});
        push_waddr(3);
        run(1'b0, 3, -1, -1);
        chk("runB_drained", exp_m.size() + waddr_q.size(), 0);
        exp_a = 256'd0;
        for (int k = 0; k < 16; k++) exp_a[16*k +: 16] = 16'(k + 1);
        chk("alu_a_lanes", alu_a_m, exp_a);
        chk("alu_a_lane0", alu_a_m[15:0], 256'd1);
        chk("alu_hold", {alu_w_m[127:0], alu_bias_m}, 256'h3);

        // Run C: reset during LOAD_W of neuron 1; only neuron 0 may be written
        chk_waddr = 1'b0;
        exp_m.push_back({10'd0, 16'h0001});
        run(1'b0, 3, -1, 45);
        repeat (2) @(negedge clk);
        chk("runC_drained", exp_m.size(), 0);

        // Run D: fresh start after reset completes from neuron 0
        exp_m.push_back({10'd0, 16'h0001});
        exp_m.push_back({10'd1, 16'h0002});
        exp_m.push_back({10'd2, 16'h0003});
        push_waddr(3); chk_waddr = 1'b1;
        run(1'b0, 3, -1, -1);
        chk("runD_drained", exp_m.size() + waddr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
